// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared SPI frame widths, FSM state encoding and frame check
package spi_frame_pkg;
  localparam int CNT_W = 14;
  localparam int PAD_W = 2;
  localparam int BYTE_W = 8;
  localparam int FRAME_BITS = 16;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, RX_HIGH, RX_LOW, OVERRUN} state_t;
  function automatic logic frame_ok(input logic [BYTE_W-1:0] hi);
    return hi[BYTE_W-1 -: PAD_W] == '0;
  endfunction
endpackage

// File: rtl/spi_counter_receiver_if.sv
// spi_counter_receiver_if: SPI bus wires between master and counter receiver
interface spi_counter_receiver_if;
  logic sclk, mosi, ss, miso;
  modport master(output sclk, mosi, ss, input miso);
  modport slave(input sclk, mosi, ss, output miso);
endinterface

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: input synchronizers, edge detection, rx/tx shift registers and bit counter
module spi_slave_shift
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  input  logic              active,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              sclk_rise,
  output logic              ss_fall,
  output logic              ss_rise,
  output logic              mosi_s,
  output logic [BYTE_W-1:0] rx_byte,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              miso
);
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
  logic sclk_s, ss_s, sclk_d, ss_d, sclk_fall;
  logic [BYTE_W-1:0] tx_sr;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall = ~ss_s & ss_d;
  assign ss_rise = ss_s & ~ss_d;
  assign miso = ~ss_s & tx_sr[BYTE_W-1];
  // synchronizers and edge history, resetting to the idle bus levels
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_q <= '1;
      sclk_d <= 1'b0;
      ss_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_q <= {ss_q[SYNC_STAGES-2:0], ss};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
    end
  // frame start loads the reply; rising edges sample mosi, falling edges advance miso
  // and after the 8th bit the reply switches to the just-received high byte
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_byte <= '0;
      tx_sr <= '0;
      bit_cnt <= '0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
      tx_sr <= tx_data;
    end else if (active) begin
      if (sclk_rise) begin
        rx_byte <= {rx_byte[BYTE_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (sclk_fall) tx_sr <= (bit_cnt == BIT_W'(BYTE_W)) ? rx_byte : {tx_sr[BYTE_W-2:0], 1'b0};
    end
endmodule

// File: rtl/spi_counter_receiver.sv
// spi_counter_receiver: SPI mode-0 slave taking 16-bit counter frames; SPI_RX_ERR_CNT_EN enables the rejected-frame counter
module spi_counter_receiver
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_counter_receiver_if.slave spi,
  output logic [CNT_W-1:0]     o_counter,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic [7:0]           o_err_count
);
  state_t state, state_nx;
  logic sclk_rise, ss_fall, ss_rise, mosi_s, active, hi_done, done, abort;
  logic [BYTE_W-1:0] rx_byte, rx_next, hi_byte, good_cnt;
  logic [BIT_W-1:0] bit_cnt;
  assign active = state inside {RX_HIGH, RX_LOW};
  assign rx_next = {rx_byte[BYTE_W-2:0], mosi_s};
  assign hi_done = state == RX_HIGH && sclk_rise && bit_cnt == BIT_W'(BYTE_W - 1);
  assign done = state == RX_LOW && sclk_rise && bit_cnt == BIT_W'(FRAME_BITS - 1);
  assign abort = active && ss_rise && !done;
  spi_slave_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk(clk),
    .reset(reset),
    .sclk(spi.sclk),
    .mosi(spi.mosi),
    .ss(spi.ss),
    .active(active),
    .tx_data(good_cnt),
    .sclk_rise(sclk_rise),
    .ss_fall(ss_fall),
    .ss_rise(ss_rise),
    .mosi_s(mosi_s),
    .rx_byte(rx_byte),
    .bit_cnt(bit_cnt),
    .miso(spi.miso)
  );
  // frame sequencing; a frame completing on the same cycle ss rises goes straight to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ss_fall ? RX_HIGH : IDLE;
      RX_HIGH: state_nx = ss_rise ? IDLE : hi_done ? RX_LOW : RX_HIGH;
      RX_LOW:  state_nx = ss_rise ? IDLE : done ? OVERRUN : RX_LOW;
      default: state_nx = ss_rise ? IDLE : OVERRUN;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // latch the high byte, evaluate finished frames and count good ones for the reply
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi_byte <= '0;
      o_counter <= '0;
      o_valid <= 1'b0;
      o_frame_err <= 1'b0;
      good_cnt <= '0;
    end else begin
      o_valid <= done && frame_ok(hi_byte);
      o_frame_err <= (done && !frame_ok(hi_byte)) || abort;
      if (hi_done) hi_byte <= rx_next;
      if (done && frame_ok(hi_byte)) begin
        o_counter <= {hi_byte[CNT_W-BYTE_W-1:0], rx_next};
        good_cnt <= good_cnt + 8'd1;
      end
    end
`ifdef SPI_RX_ERR_CNT_EN
  // saturating count of rejected frames
  always_ff @(posedge clk or posedge reset)
    if (reset) o_err_count <= '0;
    else if (o_frame_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
`else
  assign o_err_count = '0;
`endif
endmodule

// File: doc/spi_counter_receiver.md
SPI_COUNTER_RECEIVER -- requirements
Module: spi_counter_receiver

Interface
REQ-001 SYNC_STAGES, 2, synchronizer depth for sclk/mosi/ss (legal values 2..3).
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 sclk  input  1  SPI clock from master, mode 0 (idle low, sample on rising edge), MSB first.
REQ-005 mosi  input  1  serial data from master.
REQ-006 ss  input  1  slave select, active low; one low interval is one frame.
REQ-007 miso  output  1  serial reply to master.
REQ-008 o_counter  output  14  last successfully received counter value.
REQ-009 o_valid  output  1  one-cycle pulse when o_counter is updated.
REQ-010 o_frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-011 o_err_count  output  8  rejected-frame count (see Configuration).

Function
REQ-012 sclk, mosi and ss SHALL each pass through a SYNC_STAGES flip-flop synchronizer before use; supported sclk frequency is at most clk/8.
REQ-013 The block SHALL detect sclk rising and falling edges and the ss falling and rising edges from the synchronized signals, each as a one-clk pulse.
REQ-014 The FSM states SHALL be IDLE, RX_HIGH, RX_LOW and OVERRUN.
REQ-015 IDLE -> RX_HIGH on an ss falling edge; the bit counter is cleared and the tx shift register is loaded.
REQ-016 In RX_HIGH and RX_LOW, each sclk rising edge SHALL shift synchronized mosi into the LSB of an 8-bit shift register.
REQ-017 RX_HIGH -> RX_LOW after the 8th bit; the high byte is latched internally.
REQ-018 RX_LOW -> OVERRUN after the 16th bit; on that bit the frame is evaluated.
REQ-019 Frame evaluation: if high byte [7:6] == 2'b00, o_counter = {high[5:0], low[7:0]} and o_valid pulses in the clk cycle after the 16th-bit edge pulse; otherwise o_frame_err pulses in that cycle and o_counter is held.
REQ-020 In OVERRUN, further sclk edges SHALL be ignored; ss rising edge -> IDLE.
REQ-021 An ss rising edge in RX_HIGH or RX_LOW (fewer than 16 bits) SHALL abort the frame: o_frame_err pulses once, o_counter is held, state -> IDLE.
REQ-022 An ss falling edge with no sclk activity, followed by an ss rising edge, SHALL be treated as an aborted frame (REQ-021).
REQ-023 o_valid and o_frame_err SHALL never be asserted in the same cycle, and neither SHALL be asserted longer than one cycle.
REQ-024 miso SHALL be 0 whenever synchronized ss is high.
REQ-025 In a frame, miso SHALL shift out MSB-first, changing on sclk falling edges: byte 0 = 8-bit count of good frames (wraps 255 -> 0), byte 1 = high byte received in byte 0 of the current frame.
REQ-026 The first miso bit SHALL be driven from the ss falling edge onward, before the first sclk rising edge.
REQ-027 Sclk edges while ss is high SHALL have no effect.

Reset
REQ-028 Reset SHALL force state IDLE, o_counter = 0, o_valid = 0, o_frame_err = 0, o_err_count = 0, miso = 0, good-frame count = 0, synchronizers to the idle levels (ss = 1, sclk = 0, mosi = 0).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without a pulse on o_valid or o_frame_err; after release the block waits for a new ss falling edge.

Configuration
REQ-030 Macro SPI_RX_ERR_CNT_EN defined: o_err_count increments on every o_frame_err pulse and saturates at 255.
REQ-031 Macro not defined: o_err_count is tied to 0 and the counter logic is not generated; all other behaviour is identical.

Structure
REQ-032 Package spi_frame_pkg SHALL hold the FSM state enum, CNT_W = 14, PAD_W = 2, BYTE_W = 8 and FRAME_BITS = 16, shared with the transmit side.
REQ-033 Sub-module spi_slave_shift SHALL contain the synchronizers, edge detectors, rx/tx shift registers and bit counter; the top holds the FSM, frame check and outputs.

Verification
REQ-034 Frame 0x12, 0x34 at sclk = clk/10 -> o_counter = 14'h1234, exactly one o_valid pulse, no o_frame_err.
REQ-035 Back-to-back frames 0x3F,0xFF then 0x00,0x00 -> o_counter 14'h3FFF then 14'h0000, two o_valid pulses; miso byte 0 of the second frame = 0x01.
REQ-036 Frame 0xC1, 0x00 -> o_frame_err pulse, o_counter held at its prior value, and o_err_count = 1 when SPI_RX_ERR_CNT_EN is defined (0 otherwise).
REQ-037 ss released after 5 bits -> one o_frame_err pulse, state IDLE; the next full frame 0x00, 0x07 -> o_counter = 14'h0007.
REQ-038 Frame with 20 sclk pulses 0x01, 0x02, then 4 extra bits -> o_counter = 14'h0102, a single o_valid pulse, and the extra bits ignored.
REQ-039 Reset asserted after 10 bits -> all outputs are at their reset values, with no o_valid or o_frame_err pulse.
